// File: rtl/fetch_align_pkg.sv
// Shared definitions for the fetch/align stage: parcel geometry, FSM encoding
// and the instruction length decode that decode also relies on.
package fetch_align_pkg;

   localparam int PARCEL_W    = 16;
   localparam int BUF_PARCELS = 8;

   localparam logic [2:0] PARCEL_LEN_16 = 3'd1;
   localparam logic [2:0] PARCEL_LEN_32 = 3'd2;
   localparam logic [2:0] PARCEL_LEN_64 = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_e;

   function automatic logic [2:0] parcel_need(input logic [PARCEL_W-1:0] first);
      logic [2:0] len;
      if (first[15] == 1'b0) begin
         len = PARCEL_LEN_16;
      end else if (first[14] == 1'b0) begin
         len = PARCEL_LEN_32;
      end else begin
         len = PARCEL_LEN_64;
      end
      return len;
   endfunction

   // Parcel 0 lives in the most significant bits of a fetch word.
   function automatic logic [PARCEL_W-1:0] word_parcel(input logic [63:0] word,
                                                       input logic [1:0]  idx);
      logic [PARCEL_W-1:0] p;
      case (idx)
         2'd0:    p = word[63:48];
         2'd1:    p = word[47:32];
         2'd2:    p = word[31:16];
         2'd3:    p = word[15:0];
         default: p = 16'h0000;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/fetch_align_parcel_buf.sv
// Eight-entry parcel queue: shifts out consumed parcels toward q0, then appends
// the useful parcels of a fetch word behind the survivors.
module fetch_align_parcel_buf
   import fetch_align_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [2:0]  consume_len,
   input  logic        append,
   input  logic [1:0]  append_skip,
   input  logic [63:0] append_data,
   output logic [63:0] inst_out,
   output logic [3:0]  count
);

   logic [PARCEL_W-1:0] q_r     [BUF_PARCELS];
   logic [PARCEL_W-1:0] q_nxt_s [BUF_PARCELS];
   logic [PARCEL_W-1:0] q_sh_s  [BUF_PARCELS];
   logic [3:0]          count_r;
   logic [3:0]          count_sh_s;
   logic [3:0]          count_nxt_s;
   logic [3:0]          src_s;
   logic [3:0]          off_s;
   logic [3:0]          lane_s;

   // Next buffer contents: shift by the consumed length, then overlay the new word.
   always_comb begin
      count_sh_s = count_r - {1'b0, consume_len};
      src_s      = 4'd0;
      off_s      = 4'd0;
      lane_s     = 4'd0;
      for (int p = 0; p < BUF_PARCELS; p++) begin
         src_s = 4'(p) + {1'b0, consume_len};
         if (src_s < 4'(BUF_PARCELS)) begin
            q_sh_s[p] = q_r[src_s[2:0]];
         end else begin
            q_sh_s[p] = 16'h0000;
         end
         off_s  = 4'(p) - count_sh_s;
         lane_s = off_s + {2'b00, append_skip};
         if (append && (4'(p) >= count_sh_s) && (lane_s < 4'd4)) begin
            q_nxt_s[p] = word_parcel(append_data, lane_s[1:0]);
         end else begin
            q_nxt_s[p] = q_sh_s[p];
         end
      end
      if (append) begin
         count_nxt_s = count_sh_s + (4'd4 - {2'b00, append_skip});
      end else begin
         count_nxt_s = count_sh_s;
      end
   end

   // Parcel storage and fill level.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int p = 0; p < BUF_PARCELS; p++) begin
            q_r[p] <= 16'h0000;
         end
         count_r <= 4'd0;
      end else begin
         for (int p = 0; p < BUF_PARCELS; p++) begin
            q_r[p] <= q_nxt_s[p];
         end
         count_r <= count_nxt_s;
      end
   end

   // Present q0..q3, forcing parcels beyond the fill level to zero.
   always_comb begin
      inst_out = 64'h0;
      for (int i = 0; i < 4; i++) begin
         if (4'(i) < count_r) begin
            inst_out[63-16*i -: 16] = q_r[i];
         end else begin
            inst_out[63-16*i -: 16] = 16'h0000;
         end
      end
   end

   assign count = count_r;

endmodule

// File: rtl/fetch_align.sv
// Fetch/align stage: issues aligned 64-bit fetches, keeps the parcel buffer fed,
// tracks the decode PC and rejects advances that do not match the instruction length.
module fetch_align
   import fetch_align_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic        imem_rvalid,
   input  logic [63:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [63:0] inst_out,
   output logic        inst_valid,
   output logic [63:0] pc_out,
   input  logic        advance16,
   input  logic        advance32,
   input  logic        advance64,
   output logic        err_advance
);

   fetch_state_e state_r;
   fetch_state_e state_nxt_s;
   logic [63:0]  fetch_addr_r;
   logic [1:0]   skip_r;
   logic [63:0]  pc_r;
   logic         err_r;

   logic [3:0]   count_s;
   logic [2:0]   need_s;
   logic [2:0]   adv_vec_s;
   logic [2:0]   adv_len_s;
   logic         adv_legal_s;
   logic         adv_err_s;
   logic [2:0]   consume_len_s;
   logic         append_s;

   fetch_align_parcel_buf u_buf (
      .clk         (clk),
      .rst         (rst),
      .clear       (redirect_valid),
      .consume_len (consume_len_s),
      .append      (append_s),
      .append_skip (skip_r),
      .append_data (imem_rdata),
      .inst_out    (inst_out),
      .count       (count_s)
   );

   assign need_s     = parcel_need(inst_out[63:48]);
   assign inst_valid = ({1'b0, need_s} <= count_s);
   assign adv_vec_s  = {advance64, advance32, advance16};

   // Advance legality: exactly one strobe whose length matches the presented instruction.
   always_comb begin
      case (adv_vec_s)
         3'b001:  adv_len_s = PARCEL_LEN_16;
         3'b010:  adv_len_s = PARCEL_LEN_32;
         3'b100:  adv_len_s = PARCEL_LEN_64;
         default: adv_len_s = 3'd0;
      endcase
      if ((adv_len_s != 3'd0) && inst_valid && (adv_len_s == need_s)) begin
         adv_legal_s = 1'b1;
      end else begin
         adv_legal_s = 1'b0;
      end
      adv_err_s = (adv_vec_s != 3'b000) && !adv_legal_s;
      if (adv_legal_s && !redirect_valid) begin
         consume_len_s = adv_len_s;
      end else begin
         consume_len_s = 3'd0;
      end
   end

   assign append_s = (state_r == ST_WAIT) && imem_rvalid && !redirect_valid;

   // Fetch sequencing; a redirect turns the one outstanding response into a discard.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (redirect_valid || (count_s <= 4'd4)) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (imem_ack && redirect_valid) begin
               state_nxt_s = ST_DISCARD;
            end else if (imem_ack) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               state_nxt_s = ST_DISCARD;
            end else if (imem_rvalid) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DISCARD: begin
            // A further redirect still waits on the same stale response.
            if (imem_rvalid) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DISCARD;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, fetch address, skip, decode PC and advance error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         fetch_addr_r <= {RESET_PC[63:3], 3'b000};
         skip_r       <= RESET_PC[2:1];
         pc_r         <= {RESET_PC[63:1], 1'b0};
         err_r        <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         err_r   <= adv_err_s;
         if (redirect_valid) begin
            fetch_addr_r <= {redirect_pc[63:3], 3'b000};
            skip_r       <= redirect_pc[2:1];
            pc_r         <= {redirect_pc[63:1], 1'b0};
         end else begin
            if (append_s) begin
               fetch_addr_r <= fetch_addr_r + 64'd8;
               skip_r       <= 2'b00;
            end else begin
               fetch_addr_r <= fetch_addr_r;
               skip_r       <= skip_r;
            end
            pc_r <= pc_r + {60'd0, consume_len_s, 1'b0};
         end
      end
   end

   assign imem_req    = (state_r == ST_REQ);
   assign imem_addr   = fetch_addr_r;
   assign pc_out      = pc_r;
   assign err_advance = err_r;

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align with a small one-outstanding memory model.
`timescale 1ns/1ps
module tb_fetch_align;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [63:0] imem_rdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] inst_out;
   logic        inst_valid;
   logic [63:0] pc_out;
   logic        advance16, advance32, advance64;
   logic        err_advance;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        ack_en, rv_en, pend;
   logic [63:0] pend_addr, last_addr;
   int          req_cnt = 0;
   int          req_base;

   fetch_align #(.RESET_PC(64'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_out(inst_out), .inst_valid(inst_valid), .pc_out(pc_out),
      .advance16(advance16), .advance32(advance32), .advance64(advance64),
      .err_advance(err_advance)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      case (a)
         64'h00:  return 64'h0001_8002_0003_C004;
         64'h08:  return 64'h0005_0006_0007_0008;
         64'h10:  return 64'h1111_2222_3333_4444;
         64'h18:  return 64'hBAD0_BAD1_BAD2_BAD3;
         64'h40:  return 64'hC001_0002_0003_0004;
         64'h48:  return 64'h0101_0202_0303_0404;
         default: return 64'hEEEE_EEEE_EEEE_EEEE;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_adv(input logic [2:0] v);
      @(negedge clk);
      {advance64, advance32, advance16} = v;
      @(posedge clk); #1;
      {advance64, advance32, advance16} = 3'b000;
   endtask

   task automatic do_redirect(input logic [63:0] pc);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 30; i++) begin
         if (inst_valid) break;
         @(posedge clk); #1;
      end
      check_val(tag, {63'd0, inst_valid}, 64'd1);
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 30; i++) begin
         if (imem_req) break;
         @(posedge clk); #1;
      end
      check_val(tag, {63'd0, imem_req}, 64'd1);
   endtask

   // Memory: ack on a negedge while requesting, data on a later negedge once enabled.
   initial begin
      pend = 1'b0;
      pend_addr = 64'h0;
      last_addr = 64'h0;
      imem_ack = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = 64'h0;
      forever begin
         @(negedge clk);
         imem_ack    = 1'b0;
         imem_rvalid = 1'b0;
         if (pend && rv_en) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
         end else if (!pend && imem_req && ack_en) begin
            imem_ack  = 1'b1;
            pend      = 1'b1;
            pend_addr = imem_addr;
            last_addr = imem_addr;
            req_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      ack_en = 1'b0;
      rv_en = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 64'h0;
      {advance64, advance32, advance16} = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_req",   {63'd0, imem_req},    64'd0);
      check_val("rst_valid", {63'd0, inst_valid},  64'd0);
      check_val("rst_inst",  inst_out,             64'h0);
      check_val("rst_pc",    pc_out,               64'h0);
      check_val("rst_addr",  imem_addr,            64'h0);
      check_val("rst_err",   {63'd0, err_advance}, 64'd0);

      // Fill with instant memory, then consume 16/32/64-bit instructions.
      @(negedge clk);
      rst = 1'b0;
      ack_en = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_val("full_no_req", {63'd0, imem_req}, 64'd0);
         @(posedge clk); #1;
      end
      check_val("fill_reqs", 64'(req_cnt), 64'd2);
      check_val("t1_inst0",  inst_out, 64'h0001_8002_0003_C004);
      check_val("t1_pc0",    pc_out,   64'h0);
      check_val("t1_valid0", {63'd0, inst_valid}, 64'd1);
      ack_en = 1'b0;
      do_adv(3'b001);
      check_val("t1_inst1", inst_out, 64'h8002_0003_C004_0005);
      check_val("t1_pc1",   pc_out,   64'd2);
      check_val("t1_err1",  {63'd0, err_advance}, 64'd0);
      do_adv(3'b010);
      check_val("t1_inst2", inst_out, 64'hC004_0005_0006_0007);
      check_val("t1_pc2",   pc_out,   64'd6);
      do_adv(3'b100);
      check_val("t1_inst3", inst_out, 64'h0008_0000_0000_0000);
      check_val("t1_pc3",   pc_out,   64'd14);

      // Illegal advances leave state untouched.
      do_adv(3'b010);
      check_val("t4_err_len",  {63'd0, err_advance}, 64'd1);
      check_val("t4_pc_len",   pc_out,   64'd14);
      check_val("t4_inst_len", inst_out, 64'h0008_0000_0000_0000);
      @(posedge clk); #1;
      check_val("t4_err_pulse", {63'd0, err_advance}, 64'd0);
      do_adv(3'b011);
      check_val("t4_err_multi", {63'd0, err_advance}, 64'd1);
      check_val("t4_pc_multi",  pc_out, 64'd14);
      do_adv(3'b001);
      check_val("t4_pc_last",    pc_out, 64'd16);
      check_val("t4_empty_valid", {63'd0, inst_valid}, 64'd0);
      check_val("t4_empty_inst", inst_out, 64'h0);
      do_adv(3'b001);
      check_val("t4_err_empty", {63'd0, err_advance}, 64'd1);
      check_val("t4_pc_empty",  pc_out, 64'd16);

      // Redirect to 0x16 while a request is pending and unacked.
      req_base = req_cnt;
      do_redirect(64'h16);
      check_val("t2_req",   {63'd0, imem_req}, 64'd1);
      check_val("t2_addr",  imem_addr, 64'h10);
      check_val("t2_pc",    pc_out,    64'h16);
      check_val("t2_valid", {63'd0, inst_valid}, 64'd0);
      ack_en = 1'b1;
      wait_valid("t2_wait_valid");
      ack_en = 1'b0;
      check_val("t2_inst",   inst_out, 64'h4444_0000_0000_0000);
      check_val("t2_pc_hold", pc_out,  64'h16);
      check_val("t2_nreq",   64'(req_cnt - req_base), 64'd1);
      check_val("t2_lastaddr", last_addr, 64'h10);

      // Redirect while waiting for data: the late response must be dropped.
      wait_req("t3_wait_req0");
      check_val("t3_addr0", imem_addr, 64'h18);
      rv_en = 1'b0;
      ack_en = 1'b1;
      @(posedge clk); #1;
      ack_en = 1'b0;
      do_redirect(64'h40);
      check_val("t3_pc",    pc_out, 64'h40);
      check_val("t3_valid", {63'd0, inst_valid}, 64'd0);
      rv_en = 1'b1;
      wait_req("t3_wait_req1");
      check_val("t3_addr1", imem_addr, 64'h40);
      check_val("t3_dropped", inst_out, 64'h0);
      ack_en = 1'b1;
      wait_valid("t3_wait_valid");
      ack_en = 1'b0;
      check_val("t3_inst", inst_out, 64'hC001_0002_0003_0004);
      check_val("t3_pc1",  pc_out,   64'h40);

      // Data arrival and a 64-bit consume in the same cycle.
      wait_req("t6_wait_req");
      check_val("t6_addr", imem_addr, 64'h48);
      rv_en = 1'b0;
      ack_en = 1'b1;
      @(posedge clk); #1;
      ack_en = 1'b0;
      rv_en = 1'b1;
      do_adv(3'b100);
      check_val("t6_inst",  inst_out, 64'h0101_0202_0303_0404);
      check_val("t6_pc",    pc_out,   64'h48);
      check_val("t6_valid", {63'd0, inst_valid}, 64'd1);
      check_val("t6_err",   {63'd0, err_advance}, 64'd0);

      // Reset in the middle of a fetch, then a stale response outside WAIT.
      wait_req("t6_wait_req2");
      rv_en = 1'b0;
      ack_en = 1'b1;
      @(posedge clk); #1;
      ack_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("mid_rst_req",   {63'd0, imem_req},   64'd0);
      check_val("mid_rst_valid", {63'd0, inst_valid}, 64'd0);
      check_val("mid_rst_inst",  inst_out, 64'h0);
      check_val("mid_rst_pc",    pc_out,   64'h0);
      check_val("mid_rst_addr",  imem_addr, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      rv_en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_val("stale_inst",  inst_out, 64'h0);
      check_val("stale_valid", {63'd0, inst_valid}, 64'd0);
      check_val("stale_req",   {63'd0, imem_req}, 64'd1);
      check_val("stale_addr",  imem_addr, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
